decoder_3to8: RTL and testbench



---
 rtl/decoder_3to8.sv | 46 ++++
 tb/tb_decoder_3to8.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/decoder_3to8.sv
// Registered (or optionally combinational) 3-to-8 one-hot decoder with enable.
// The inactive level follows ACTIVE_LOW for both the decode and the reset value.
module decoder_3to8 #(
  parameter bit ACTIVE_LOW = 1'b0,
  parameter bit OUT_REG    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [2:0] a,
  output logic [7:0] y
);

  localparam logic [7:0] INACTIVE = ACTIVE_LOW ? 8'hFF : 8'h00;

  // Enable is tested before the select is used, so an unknown select with
  // en=0 still produces the all-inactive pattern.
  function automatic logic [7:0] decode(input logic i_en, input logic [2:0] i_sel);
    logic [7:0] v;
    v = 8'h00;
    if (i_en) v = 8'h01 << i_sel;
    return ACTIVE_LOW ? ~v : v;
  endfunction

  logic [7:0] w_dec;
  assign w_dec = decode(en, a);

  generate
    if (OUT_REG) begin : g_reg
      logic [7:0] r_y;

      // Output register: en and a are captured together at one edge.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) r_y <= INACTIVE;
        else     r_y <= w_dec;
      end

      assign y = r_y;
    end else begin : g_comb
      logic w_unused;
      assign w_unused = clk ^ rst;
      assign y        = w_dec;
    end
  endgenerate

endmodule

// File: tb/tb_decoder_3to8.sv
// Scoreboard bench for decoder_3to8: registered high/low-active instances
// checked by a monitor process, plus a combinational instance.
module tb_decoder_3to8;

  logic       clk;
  logic       rst;
  logic       en;
  logic [2:0] a;
  logic [7:0] y_reg;
  logic [7:0] y_al;
  logic [7:0] y_comb;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] hi;
    logic [7:0] lo;
    string      name;
  } exp_t;

  exp_t q[$];

  decoder_3to8 #(.ACTIVE_LOW(1'b0), .OUT_REG(1'b1)) u_dut (
    .clk(clk), .rst(rst), .en(en), .a(a), .y(y_reg)
  );

  decoder_3to8 #(.ACTIVE_LOW(1'b1), .OUT_REG(1'b1)) u_dut_al (
    .clk(clk), .rst(rst), .en(en), .a(a), .y(y_al)
  );

  decoder_3to8 #(.ACTIVE_LOW(1'b0), .OUT_REG(1'b0)) u_dut_comb (
    .clk(clk), .rst(rst), .en(en), .a(a), .y(y_comb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, req, $time);
    end
  endtask

  // Monitor: one registered result is due just after each edge that follows
  // an issued vector.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk({e.name, "_hi"}, y_reg, e.hi);
      chk({e.name, "_lo"}, y_al,  e.lo);
    end
  end

  // Apply a vector between edges and post its expected registered response.
  task automatic step(input string name, input logic e_in, input logic [2:0] s,
                      input logic [7:0] hi, input logic [7:0] lo);
    exp_t x;
    @(negedge clk);
    en = e_in;
    a  = s;
    x.hi   = hi;
    x.lo   = lo;
    x.name = name;
    q.push_back(x);
  endtask

  initial begin
    logic [7:0] model;
    rst = 1'b1;
    en  = 1'b0;
    a   = 3'd0;
    #1;
    chk("reset_init_hi", y_reg, 8'h00);
    chk("reset_init_lo", y_al,  8'hFF);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    step("en0_a0", 1'b0, 3'd0, 8'h00, 8'hFF);
    step("a0",     1'b1, 3'd0, 8'h01, 8'hFE);
    step("a1",     1'b1, 3'd1, 8'h02, 8'hFD);
    step("a2",     1'b1, 3'd2, 8'h04, 8'hFB);
    step("a3",     1'b1, 3'd3, 8'h08, 8'hF7);
    step("a4",     1'b1, 3'd4, 8'h10, 8'hEF);
    step("a5",     1'b1, 3'd5, 8'h20, 8'hDF);
    step("a6",     1'b1, 3'd6, 8'h40, 8'hBF);
    step("a7",     1'b1, 3'd7, 8'h80, 8'h7F);
    step("dis_a5", 1'b0, 3'd5, 8'h00, 8'hFF);
    step("both_a6",1'b1, 3'd6, 8'h40, 8'hBF);
    step("al_a2",  1'b1, 3'd2, 8'h04, 8'hFB);
    step("a3_pre", 1'b1, 3'd3, 8'h08, 8'hF7);
    @(posedge clk);
    #2;

    // Asynchronous reset pulse between edges, with en=1 a=3 still applied.
    rst = 1'b1;
    #1;
    chk("rst_async_hi", y_reg, 8'h00);
    chk("rst_async_lo", y_al,  8'hFF);
    @(posedge clk);
    #1;
    chk("rst_hold_hi", y_reg, 8'h00);
    chk("rst_hold_lo", y_al,  8'hFF);
    @(negedge clk);
    rst = 1'b0;
    begin
      exp_t x;
      x.hi = 8'h08; x.lo = 8'hF7; x.name = "rst_release";
      q.push_back(x);
    end

    // Unknown select while disabled must still decode to inactive.
    step("dis_ax", 1'b0, 3'bxxx, 8'h00, 8'hFF);
    step("a1_end", 1'b1, 3'd1, 8'h02, 8'hFD);

    // Combinational instance: checked before the next edge arrives.
    @(negedge clk);
    en = 1'b1;
    a  = 3'd6;
    #1;
    chk("comb_a6", y_comb, 8'h40);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      en = i[3];
      a  = i[2:0];
      #1;
      model = en ? (8'h01 << a) : 8'h00;
      chk($sformatf("comb_en%0d_a%0d", i[3], i[2:0]), y_comb, model);
    end

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 20 && q.size() > 0; k++) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain actual=%0d required=0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
